// File: rtl/ks_pg_input_stage.sv
// ks_pg_input_stage
//   Head stage of the pipelined Kogge-Stone adder. Operands A/B and carry-in
//   arrive on a valid/ready handshake; the bitwise propagate (A ^ B) and
//   generate (A & B) vectors plus the carry-in are registered and handed to
//   the prefix layers through a 2-entry skid buffer (output register + skid
//   entry). Full throughput: an input and an output transfer may happen on
//   the same edge.
//
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both high. A source holding valid without ready must keep its data
//   stable. out_valid never drops without an output transfer, and
//   pg_p/pg_g/pg_cin hold steady while out_valid=1 and out_ready=0.
//   in_ready is a register output and never depends combinationally on
//   out_ready.
module ks_pg_input_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pg_p,
  output logic [WIDTH-1:0] pg_g,
  output logic             pg_cin
);

  // Occupancy encoding: number of buffered operand sets.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_in_ready;

  logic [WIDTH-1:0] r_out_p;
  logic [WIDTH-1:0] r_out_g;
  logic             r_out_cin;
  logic [WIDTH-1:0] r_skid_p;
  logic [WIDTH-1:0] r_skid_g;
  logic             r_skid_cin;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_out_valid;
  logic             w_load_out_in;
  logic             w_load_out_skid;
  logic             w_load_skid;

  // Bitwise propagate/generate; no carry chain, every bit is independent.
  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = w_out_valid & out_ready;

  // State register; in_ready is registered alongside it from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // Next-state logic: occupancy follows input/output transfers.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) w_state_nxt = ST_ONE;
      end
      ST_ONE: begin
        if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_TWO;
        else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
        else                               w_state_nxt = ST_ONE;
      end
      ST_TWO: begin
        // in_ready is low here, so only an output transfer can occur.
        if (w_out_xfer) w_state_nxt = ST_ONE;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output/datapath control decoded from the current state and transfers.
  always_comb begin
    w_out_valid     = 1'b0;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_load_out_in = w_in_xfer;
      end
      ST_ONE: begin
        w_out_valid   = 1'b1;
        // Output register frees up this edge: new data goes straight in.
        w_load_out_in = w_in_xfer & w_out_xfer;
        // Output register stalled: new data parks in the skid entry.
        w_load_skid   = w_in_xfer & ~w_out_xfer;
      end
      ST_TWO: begin
        w_out_valid     = 1'b1;
        w_load_out_skid = w_out_xfer;
      end
      default: begin
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Output register: loads either fresh P/G/cin or the parked skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_p   <= '0;
      r_out_g   <= '0;
      r_out_cin <= 1'b0;
    end else if (w_load_out_in) begin
      r_out_p   <= w_p;
      r_out_g   <= w_g;
      r_out_cin <= cin;
    end else if (w_load_out_skid) begin
      r_out_p   <= r_skid_p;
      r_out_g   <= r_skid_g;
      r_out_cin <= r_skid_cin;
    end
  end

  // Skid entry: captures data accepted while the output register is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_p   <= '0;
      r_skid_g   <= '0;
      r_skid_cin <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_p   <= w_p;
      r_skid_g   <= w_g;
      r_skid_cin <= cin;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign pg_p      = r_out_p;
  assign pg_g      = r_out_g;
  assign pg_cin    = r_out_cin;

endmodule

// File: tb/tb_ks_pg_input_stage.sv
// Bench for ks_pg_input_stage: directed scenarios followed by random traffic,
// all checked against a capacity-2 FIFO reference model of (a^b, a&b, cin).
module tb_ks_pg_input_stage;

  localparam int W = 16;
  localparam int EW = 2 * W + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  pg_p;
  logic [W-1:0]  pg_g;
  logic          pg_cin;

  // Expected entries packed as {cin, g, p}.
  logic [EW-1:0] exp_q[$];

  int total;
  int bad;

  logic          prev_stall;
  logic [EW-1:0] prev_out;

  ks_pg_input_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pg_p      (pg_p),
    .pg_g      (pg_g),
    .pg_cin    (pg_cin)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ref_entry(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rc);
    logic [W-1:0] p;
    logic [W-1:0] g;
    for (int i = 0; i < W; i++) begin
      p[i] = (ra[i] + rb[i]) == 1;
      g[i] = (ra[i] + rb[i]) == 2;
    end
    return {rc, g, p};
  endfunction

  // One clock cycle, entered and left at a falling edge. Drives inputs,
  // checks the outputs against the model, then applies this edge's transfers.
  task automatic step(input logic iv, input logic [W-1:0] da, input logic [W-1:0] db,
                      input logic dc, input logic ordy, output logic accepted);
    logic in_x;
    logic out_x;
    in_valid  = iv;
    a         = da;
    b         = db;
    cin       = dc;
    out_ready = ordy;
    #1;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    if (exp_q.size() != 0) check("pg_data", {pg_cin, pg_g, pg_p}, exp_q[0]);
    if (prev_stall) check("stall_stable", {pg_cin, pg_g, pg_p}, prev_out);
    in_x  = iv && (exp_q.size() < 2);
    out_x = ordy && (exp_q.size() != 0);
    prev_stall = (exp_q.size() != 0) && !ordy;
    prev_out   = {pg_cin, pg_g, pg_p};
    @(posedge clk);
    if (out_x) void'(exp_q.pop_front());
    if (in_x) exp_q.push_back(ref_entry(da, db, dc));
    accepted = in_x;
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    logic pend;
    int ops;
    int cyc;

    total = 0;
    bad = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    rst_n = 1'b0;
    in_valid = 1'b1;   // ignored during reset
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_pg", {pg_cin, pg_g, pg_p}, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single op
    step(1'b1, 16'h00FF, 16'h0F0F, 1'b1, 1'b1, acc);
    check("single_acc", acc, 1);
    #1;
    check("single_valid", out_valid, 1);
    check("single_p", pg_p, 16'h0FF0);
    check("single_g", pg_g, 16'h000F);
    check("single_cin", pg_cin, 1);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Back-to-back: 8 ops, in_ready must stay high
    for (int i = 0; i < 8; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, acc);
      check("b2b_acc", acc, 1);
    end
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Backpressure: X, Y accepted, Z held
    step(1'b1, 16'h1234, 16'hFFFF, 1'b0, 1'b0, acc);
    check("bp_x_acc", acc, 1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, acc);  // all-ones: P=0, G=all-ones
    check("bp_y_acc", acc, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, acc);
      check("bp_z_held", acc, 0);
    end
    pend = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(pend, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1, acc);
      if (acc) pend = 1'b0;
    end
    check("bp_z_taken", pend, 0);
    check("bp_drained", exp_q.size(), 0);

    // Simultaneous in+out transfer in ONE
    step(1'b1, 16'h0001, 16'h0003, 1'b0, 1'b0, acc);
    step(1'b1, 16'hF0F0, 16'h3C3C, 1'b1, 1'b1, acc);
    #1;
    check("simul_valid", out_valid, 1);
    check("simul_in_ready", in_ready, 1);
    check("simul_data", {pg_cin, pg_g, pg_p}, {1'b1, 16'h3030, 16'hCCCC});
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Reset mid-stream in TWO
    step(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, acc);
    step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, acc);
    check("pre_rst_full", exp_q.size(), 2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_pg", {pg_cin, pg_g, pg_p}, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h8001, 16'h0001, 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("post_rst_empty", exp_q.size(), 0);

    // Random traffic: 10k accepted ops with random valid/ready
    ops = 0;
    cyc = 0;
    pend = 1'b0;
    ra = '0;
    rb = '0;
    rc = 1'b0;
    while (ops < 10000 && cyc < 60000) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1;
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
      end
      step(pend, pend ? ra : W'($urandom), pend ? rb : W'($urandom), pend ? rc : 1'($urandom),
           1'($urandom_range(0, 2) != 0), acc);
      if (acc) begin
        pend = 1'b0;
        ops++;
      end
      cyc++;
    end
    check("rand_ops_done", ops, 10000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      cyc++;
    end
    check("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
